// File: rtl/addr_reg_bank_if.sv
// addr_reg_bank_if: load/request/address bus between a datapath and the address register bank
interface addr_reg_bank_if #(
   parameter int WIDTH = 16,
   parameter int NCH   = 2
);
   logic [NCH*WIDTH-1:0] addr_in;
   logic [NCH-1:0]       wren;
   logic [NCH-1:0]       inc;
   logic [NCH-1:0]       dec;
   logic [NCH*WIDTH-1:0] addr_out;
   logic [NCH-1:0]       wrap;
   modport master (output addr_in, wren, inc, dec, input addr_out, wrap);
   modport slave  (input addr_in, wren, inc, dec, output addr_out, wrap);
endinterface

// File: rtl/addr_reg_bank.sv
// addr_reg_bank: multi-channel address registers with write-through load, post-increment, pre-decrement and sticky wrap flag
module addr_reg_bank #(
   parameter int WIDTH     = 16,
   parameter int NCH       = 2,
   parameter int STEP      = 1,
   parameter int RESET_VAL = 0,
   parameter bit SATURATE  = 1'b0
) (
   input logic            clock,
   input logic            reset,
   addr_reg_bank_if.slave bus
);
   localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);
   localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VAL);
   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic [WIDTH-1:0] a_in, r_q, r_d, inc_r, dec_r;
      logic [WIDTH:0]   sum, diff;
      logic             w_q, w_d, ld, do_inc, do_dec;
      assign a_in   = bus.addr_in[g*WIDTH +: WIDTH];
      assign ld     = bus.wren[g];
      assign do_inc = !ld && bus.inc[g] && !bus.dec[g];
      assign do_dec = !ld && bus.dec[g] && !bus.inc[g];
      // Step arithmetic in WIDTH+1 bits; the top bit is the carry/borrow that marks a wrap or clamp
      always_comb begin
         sum   = {1'b0, r_q} + STEP_X;
         diff  = {1'b0, r_q} - STEP_X;
         inc_r = (SATURATE && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
         dec_r = (SATURATE && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
         r_d   = ld ? a_in : do_inc ? inc_r : do_dec ? dec_r : r_q;
         w_d   = ld ? 1'b0 : (do_inc && sum[WIDTH]) || (do_dec && diff[WIDTH]) || w_q;
      end
      // Channel state, cleared asynchronously by reset
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_q <= RST_V;
            w_q <= 1'b0;
         end else begin
            r_q <= r_d;
            w_q <= w_d;
         end
      end
      assign bus.addr_out[g*WIDTH +: WIDTH] = reset ? RST_V : ld ? a_in : do_dec ? dec_r : r_q;
      assign bus.wrap[g] = w_q;
   end
endmodule

// File: tb/tb_addr_reg_bank.sv
// tb_addr_reg_bank: directed checks of load, inc/dec, wrap, saturation, priority and async reset
module tb_addr_reg_bank;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   addr_reg_bank_if #(.WIDTH(16), .NCH(2)) b0 ();
   addr_reg_bank_if #(.WIDTH(16), .NCH(2)) b1 ();
   addr_reg_bank #(.WIDTH(16), .NCH(2)) dut0 (.clock(clock), .reset(reset), .bus(b0.slave));
   addr_reg_bank #(.WIDTH(16), .NCH(2), .STEP(4), .SATURATE(1'b1)) dut1 (.clock(clock), .reset(reset), .bus(b1.slave));
   always #5 clock = ~clock;
   task automatic tick;
      @(posedge clock);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   initial begin
      b0.addr_in = {16'h1234, 16'hABCD};
      b0.wren = 2'b11; b0.inc = 2'b00; b0.dec = 2'b00;
      b1.addr_in = '0; b1.wren = 2'b00; b1.inc = 2'b00; b1.dec = 2'b00;
      #2;
      chk("reset_out", b0.addr_out, 32'h0);
      chk("reset_wrap", {30'h0, b0.wrap}, 32'h0);
      #1 reset = 1'b0;
      #1 chk("write_through", b0.addr_out, 32'h1234ABCD);
      tick;
      b0.wren = 2'b00;
      #1 chk("load_hold", b0.addr_out, 32'h1234ABCD);
      b0.wren = 2'b01; b0.addr_in = {16'h0000, 16'h00FF};
      tick;
      b0.wren = 2'b00; b0.inc = 2'b01;
      #1 chk("postinc0", b0.addr_out, 32'h123400FF);
      tick;
      chk("postinc1", {16'h0, b0.addr_out[15:0]}, 32'h0100);
      tick;
      chk("postinc2", {16'h0, b0.addr_out[15:0]}, 32'h0101);
      tick;
      b0.inc = 2'b00;
      #1 chk("postinc_end", b0.addr_out, 32'h12340102);
      b0.wren = 2'b10; b0.addr_in = {16'h8000, 16'h0000};
      tick;
      b0.wren = 2'b00; b0.dec = 2'b10;
      #1 chk("predec0", {16'h0, b0.addr_out[31:16]}, 32'h7FFF);
      tick;
      chk("predec1", {16'h0, b0.addr_out[31:16]}, 32'h7FFE);
      tick;
      b0.dec = 2'b00;
      #1 chk("predec_end", b0.addr_out, 32'h7FFE0102);
      b0.wren = 2'b01; b0.addr_in = {16'h0000, 16'hFFFF};
      tick;
      b0.wren = 2'b00; b0.inc = 2'b01;
      #1 chk("inc_ffff_out", {16'h0, b0.addr_out[15:0]}, 32'hFFFF);
      tick;
      b0.inc = 2'b00;
      #1 chk("wrap_inc_r", {16'h0, b0.addr_out[15:0]}, 32'h0000);
      chk("wrap_inc_flag", {30'h0, b0.wrap}, 32'h1);
      tick;
      tick;
      chk("wrap_sticky", {30'h0, b0.wrap}, 32'h1);
      b0.wren = 2'b01; b0.addr_in = {16'h0000, 16'h0010};
      #1 chk("load_wt_0010", {16'h0, b0.addr_out[15:0]}, 32'h0010);
      tick;
      b0.wren = 2'b00;
      #1 chk("wrap_cleared", {30'h0, b0.wrap}, 32'h0);
      b0.wren = 2'b01; b0.addr_in = '0;
      tick;
      b0.wren = 2'b00; b0.dec = 2'b01;
      #1 chk("dec0_out", {16'h0, b0.addr_out[15:0]}, 32'hFFFF);
      tick;
      b0.dec = 2'b00;
      #1 chk("wrap_dec_r", {16'h0, b0.addr_out[15:0]}, 32'hFFFF);
      chk("wrap_dec_flag", {30'h0, b0.wrap}, 32'h1);
      b0.wren = 2'b01; b0.inc = 2'b01; b0.dec = 2'b01; b0.addr_in = {16'h0000, 16'h0042};
      #1 chk("prio_wt", {16'h0, b0.addr_out[15:0]}, 32'h0042);
      tick;
      b0.wren = 2'b00; b0.inc = 2'b00; b0.dec = 2'b00;
      #1 chk("prio_r", b0.addr_out, 32'h7FFE0042);
      chk("prio_wrap", {30'h0, b0.wrap}, 32'h0);
      b0.inc = 2'b01; b0.dec = 2'b01;
      #1 chk("incdec_out", {16'h0, b0.addr_out[15:0]}, 32'h0042);
      tick;
      b0.inc = 2'b00; b0.dec = 2'b00;
      #1 chk("incdec_hold", {16'h0, b0.addr_out[15:0]}, 32'h0042);
      b1.wren = 2'b01; b1.addr_in = {16'h0000, 16'h0010};
      tick;
      b1.wren = 2'b00; b1.inc = 2'b01;
      tick;
      b1.inc = 2'b00;
      #1 chk("sat_inc_plain", {16'h0, b1.addr_out[15:0]}, 32'h0014);
      chk("sat_plain_wrap", {30'h0, b1.wrap}, 32'h0);
      b1.wren = 2'b11; b1.addr_in = {16'h0002, 16'hFFFE};
      tick;
      b1.wren = 2'b00; b1.inc = 2'b01; b1.dec = 2'b10;
      #1 chk("sat_out", b1.addr_out, 32'h0000FFFE);
      tick;
      b1.inc = 2'b00; b1.dec = 2'b00;
      #1 chk("sat_r", b1.addr_out, 32'h0000FFFF);
      chk("sat_wrap", {30'h0, b1.wrap}, 32'h3);
      b1.inc = 2'b01;
      tick;
      b1.inc = 2'b00;
      #1 chk("sat_limit", {16'h0, b1.addr_out[15:0]}, 32'hFFFF);
      b0.wren = 2'b10; b0.addr_in = {16'hFFFF, 16'h0000};
      tick;
      b0.wren = 2'b00; b0.inc = 2'b10;
      tick;
      b0.inc = 2'b00;
      #1 chk("pre_rst_wrap", {30'h0, b0.wrap}, 32'h2);
      #2 reset = 1'b1;
      #1 chk("async_rst_out", b0.addr_out, 32'h0);
      chk("async_rst_wrap", {30'h0, b0.wrap}, 32'h0);
      chk("async_rst_sat", {30'h0, b1.wrap}, 32'h0);
      reset = 1'b0;
      #1 chk("after_rst_r", b0.addr_out, 32'h0);
      chk("after_rst_sat_r", b1.addr_out, 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
